// File: rtl/min_max_tracker_if.sv
// rtl/min_max_tracker_if.sv - sample stream handshake into the min/max tracker
interface min_max_tracker_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );
endinterface

// File: rtl/min_max_tracker.sv
// rtl/min_max_tracker.sv - running max/min of an unsigned sample stream with saturating count
module min_max_tracker #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    min_max_tracker_if.slave in_if,
    output logic [WIDTH-1:0] max_val,
    output logic [WIDTH-1:0] min_val,
    output logic             have_data,
    output logic             new_max,
    output logic             new_min,
    output logic [CNT_W-1:0] sample_cnt,
    output logic             cnt_sat
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        TRACK = 2'd1,
        SAT   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t state;
    logic   accept;

    assign in_if.in_ready = !rst && !clear;
    assign accept         = in_if.in_valid && in_if.in_ready;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state      <= EMPTY;
            max_val    <= '0;
            min_val    <= '1;
            have_data  <= 1'b0;
            new_max    <= 1'b0;
            new_min    <= 1'b0;
            sample_cnt <= '0;
            cnt_sat    <= 1'b0;
        end else begin
            new_max <= 1'b0;
            new_min <= 1'b0;
            if (accept) begin
                case (state)
                    EMPTY: begin
                        max_val    <= in_if.in_data;
                        min_val    <= in_if.in_data;
                        new_max    <= 1'b1;
                        new_min    <= 1'b1;
                        have_data  <= 1'b1;
                        sample_cnt <= CNT_ONE;
                        // A one-bit counter is already full after the first sample.
                        if (CNT_ONE == CNT_MAX) begin
                            state   <= SAT;
                            cnt_sat <= 1'b1;
                        end else begin
                            state   <= TRACK;
                        end
                    end
                    TRACK, SAT: begin
                        if (in_if.in_data > max_val) begin
                            max_val <= in_if.in_data;
                            new_max <= 1'b1;
                        end
                        if (in_if.in_data < min_val) begin
                            min_val <= in_if.in_data;
                            new_min <= 1'b1;
                        end
                        if (state == TRACK) begin
                            sample_cnt <= sample_cnt + CNT_ONE;
                            if (sample_cnt + CNT_ONE == CNT_MAX) begin
                                state   <= SAT;
                                cnt_sat <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state <= EMPTY;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_min_max_tracker.sv
// tb/tb_min_max_tracker.sv - directed and random checks of min_max_tracker at CNT_W 8 and 3
module tb_min_max_tracker;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, clear;
    int   checks = 0;
    int   errors = 0;

    min_max_tracker_if #(.WIDTH(4)) s8 ();
    min_max_tracker_if #(.WIDTH(4)) s3 ();

    logic [3:0] max8, min8, max3, min3;
    logic       have8, have3, nmax8, nmax3, nmin8, nmin3, sat8, sat3;
    logic [7:0] cnt8;
    logic [2:0] cnt3;

    min_max_tracker #(.WIDTH(4), .CNT_W(8)) dut8 (
        .clk(clk), .rst(rst), .clear(clear), .in_if(s8.slave),
        .max_val(max8), .min_val(min8), .have_data(have8),
        .new_max(nmax8), .new_min(nmin8), .sample_cnt(cnt8), .cnt_sat(sat8)
    );

    min_max_tracker #(.WIDTH(4), .CNT_W(3)) dut3 (
        .clk(clk), .rst(rst), .clear(clear), .in_if(s3.slave),
        .max_val(max3), .min_val(min3), .have_data(have3),
        .new_max(nmax3), .new_min(nmin3), .sample_cnt(cnt3), .cnt_sat(sat3)
    );

    // Reference: the list of samples accepted since the last rst/clear.
    int q[$];
    bit exp_pmax, exp_pmin;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int q_max();
        int m = 0;
        foreach (q[i]) if (q[i] > m) m = q[i];
        return m;
    endfunction

    function automatic int q_min();
        int m = 15;
        foreach (q[i]) if (q[i] < m) m = q[i];
        return m;
    endfunction

    task automatic check_all();
        int n = q.size();
        chk("max8",  {28'd0, max8},  (n > 0) ? q_max() : 0);
        chk("min8",  {28'd0, min8},  (n > 0) ? q_min() : 15);
        chk("have8", {31'd0, have8}, (n > 0) ? 1 : 0);
        chk("nmax8", {31'd0, nmax8}, {31'd0, exp_pmax});
        chk("nmin8", {31'd0, nmin8}, {31'd0, exp_pmin});
        chk("cnt8",  {24'd0, cnt8},  (n > 255) ? 255 : n);
        chk("sat8",  {31'd0, sat8},  (n >= 255) ? 1 : 0);
        chk("max3",  {28'd0, max3},  (n > 0) ? q_max() : 0);
        chk("min3",  {28'd0, min3},  (n > 0) ? q_min() : 15);
        chk("nmax3", {31'd0, nmax3}, {31'd0, exp_pmax});
        chk("nmin3", {31'd0, nmin3}, {31'd0, exp_pmin});
        chk("cnt3",  {29'd0, cnt3},  (n > 7) ? 7 : n);
        chk("sat3",  {31'd0, sat3},  (n >= 7) ? 1 : 0);
    endtask

    task automatic step(input bit v, input logic [3:0] d, input bit c);
        bit r;
        s8.in_valid = v; s8.in_data = d;
        s3.in_valid = v; s3.in_data = d;
        clear = c;
        r = rst;
        #1;
        chk("ready8", {31'd0, s8.in_ready}, (r || c) ? 0 : 1);
        chk("ready3", {31'd0, s3.in_ready}, (r || c) ? 0 : 1);
        @(posedge clk);
        #1;
        if (r || c) begin
            q.delete();
            exp_pmax = 1'b0;
            exp_pmin = 1'b0;
        end else if (v) begin
            exp_pmax = (q.size() == 0) || (int'(d) > q_max());
            exp_pmin = (q.size() == 0) || (int'(d) < q_min());
            q.push_back(int'(d));
        end else begin
            exp_pmax = 1'b0;
            exp_pmin = 1'b0;
        end
        check_all();
    endtask

    int seq_d[6]    = '{7, 9, 2, 9, 0, 15};
    int seq_max[6]  = '{7, 9, 9, 9, 9, 15};
    int seq_min[6]  = '{7, 7, 2, 2, 0, 0};
    int seq_pmax[6] = '{1, 1, 0, 0, 0, 1};
    int seq_pmin[6] = '{1, 0, 1, 0, 1, 0};

    initial begin
        rst = 1'b1; clear = 1'b0;
        s8.in_valid = 1'b0; s8.in_data = '0;
        s3.in_valid = 1'b0; s3.in_data = '0;
        @(negedge clk);

        // Reset held two cycles, with a valid sample that must be ignored.
        step(1'b1, 4'd5, 1'b0);
        step(1'b0, 4'd0, 1'b0);
        rst = 1'b0;
        step(1'b0, 4'd0, 1'b0);

        // Spec sequence, checked against literal expectations as well as the model.
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 4'(seq_d[i]), 1'b0);
            chk("seq_max",  {28'd0, max8},  seq_max[i]);
            chk("seq_min",  {28'd0, min8},  seq_min[i]);
            chk("seq_pmax", {31'd0, nmax8}, seq_pmax[i]);
            chk("seq_pmin", {31'd0, nmin8}, seq_pmin[i]);
        end
        step(1'b0, 4'd0, 1'b0);

        // Clear with a valid sample drops it; the next sample restarts tracking.
        step(1'b1, 4'd12, 1'b1);
        step(1'b1, 4'd3, 1'b0);
        chk("clr_max", {28'd0, max8}, 3);
        chk("clr_min", {28'd0, min8}, 3);
        chk("clr_cnt", {24'd0, cnt8}, 1);

        // Nine samples saturate the 3-bit counter while extremes keep moving.
        for (int i = 0; i < 9; i++) step(1'b1, 4'(i == 7 ? 14 : (i == 8 ? 0 : 5)), 1'b0);
        chk("sat_cnt3", {29'd0, cnt3}, 7);
        chk("sat_flag3", {31'd0, sat3}, 1);

        // Gappy traffic, then a long run that saturates the 8-bit counter.
        for (int i = 0; i < 40; i++) step(($urandom_range(0, 1) == 1), 4'($urandom), 1'b0);
        for (int i = 0; i < 300; i++) step(($urandom_range(0, 3) != 0), 4'($urandom), 1'b0);
        for (int i = 0; i < 300; i++)
            step(($urandom_range(0, 2) != 0), 4'($urandom), ($urandom_range(0, 39) == 0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
